// File: rtl/uram_bank_fwd.sv
// uram_bank_fwd
//   Banked UltraRAM-style table memory with one write port and one read port.
//   2**BANK_BITS banks are interleaved on the low address bits. After reset or
//   a clear pulse, every row is zeroed by a sweep, and user traffic is ignored
//   until the sweep finishes. Reads travel down a valid/tag pipeline and return
//   exactly READ_LATENCY cycles after they are accepted. A same-cycle read and
//   write of one address can return the new data (WRITE_FIRST=1) or the old
//   data (WRITE_FIRST=0).
//
// Ports
//   clock       single clock
//   reset       asynchronous, active-high
//   clear       pulse, restarts the zero-initialisation sweep
//   init_done   high when the table accepts user traffic
//   wr_en / wr_addr / wr_data               write port
//   rd_en / rd_addr / rd_tag                read request
//   rd_valid / rd_data / rd_tag_out         read response (one-cycle pulse)
module uram_bank_fwd #(
  parameter int INDEX_WIDTH  = 12,
  parameter int DATA_WIDTH   = 64,
  parameter int BANK_BITS    = 1,
  parameter int READ_LATENCY = 5,
  parameter int TAG_WIDTH    = 8,
  parameter bit WRITE_FIRST  = 1'b1
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             clear,
  output logic                             init_done,
  input  logic                             wr_en,
  input  logic [INDEX_WIDTH+BANK_BITS-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]            wr_data,
  input  logic                             rd_en,
  input  logic [INDEX_WIDTH+BANK_BITS-1:0] rd_addr,
  input  logic [TAG_WIDTH-1:0]             rd_tag,
  output logic                             rd_valid,
  output logic [DATA_WIDTH-1:0]            rd_data,
  output logic [TAG_WIDTH-1:0]             rd_tag_out
);

  localparam int AW    = INDEX_WIDTH + BANK_BITS;
  localparam int NB    = 1 << BANK_BITS;
  localparam int BW    = (BANK_BITS > 0) ? BANK_BITS : 1;
  localparam int NSLOT = 1 << BW;
  localparam int DEPTH = 1 << INDEX_WIDTH;
  // Array read latency; the registered output stage supplies the last cycle.
  localparam int PL    = READ_LATENCY - 1;

  typedef enum logic [0:0] {ST_INIT, ST_READY} state_t;

  state_t                 state_reg, state_next;
  logic [INDEX_WIDTH-1:0] cnt_reg, cnt_next;
  logic                   ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= ST_INIT;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_INIT: begin
        if (clear) begin
          cnt_next = '0;
        end else if (cnt_reg == '1) begin
          state_next = ST_READY;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        if (clear) begin
          state_next = ST_INIT;
          cnt_next   = '0;
        end
      end
    endcase
  end

  assign ready     = (state_reg == ST_READY);
  assign init_done = ready;

  // Address split: low bits pick the bank, the rest pick the row.
  logic [BW-1:0]          wr_bank, rd_bank;
  logic [INDEX_WIDTH-1:0] wr_row, rd_row;

  if (BANK_BITS > 0) begin : g_split
    assign wr_bank = wr_addr[BW-1:0];
    assign rd_bank = rd_addr[BW-1:0];
  end else begin : g_nosplit
    assign wr_bank = '0;
    assign rd_bank = '0;
  end
  assign wr_row = wr_addr[AW-1:BANK_BITS];
  assign rd_row = rd_addr[AW-1:BANK_BITS];

  logic                   wr_acc, rd_acc, bypass;
  logic [INDEX_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0]  mem_wdata;

  assign wr_acc = wr_en && ready;
  assign rd_acc = rd_en && ready;
  assign bypass = WRITE_FIRST && rd_acc && wr_acc && (rd_addr == wr_addr);

  // During the sweep every bank writes zero to the counter row at once.
  assign mem_waddr = ready ? wr_row  : cnt_reg;
  assign mem_wdata = ready ? wr_data : '0;

  logic [DATA_WIDTH-1:0] bank_dout [NSLOT];

  for (genvar gi = 0; gi < NSLOT; gi++) begin : g_bank
    if (gi < NB) begin : g_mem
      logic [DATA_WIDTH-1:0] mem [DEPTH];
      logic [DATA_WIDTH-1:0] dout_pipe [PL];
      logic                  we;

      assign we = ready ? (wr_en && (wr_bank == BW'(gi))) : 1'b1;

      // Read port is always enabled; the read happens before the write on the
      // same edge, which gives the native read-first behaviour.
      always_ff @(posedge clock) begin
        if (we) begin
          mem[mem_waddr] <= mem_wdata;
        end
        dout_pipe[0] <= mem[rd_row];
        for (int k = 1; k < PL; k++) begin
          dout_pipe[k] <= dout_pipe[k-1];
        end
      end

      assign bank_dout[gi] = dout_pipe[PL-1];
    end else begin : g_empty
      assign bank_dout[gi] = '0;
    end
  end

  // Side pipeline aligned with the array read latency.
  logic                  valid_pipe [PL];
  logic [TAG_WIDTH-1:0]  tag_pipe   [PL];
  logic [BW-1:0]         bank_pipe  [PL];
  logic                  byp_pipe   [PL];
  logic [DATA_WIDTH-1:0] bypd_pipe  [PL];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < PL; k++) begin
        valid_pipe[k] <= 1'b0;
        tag_pipe[k]   <= '0;
        bank_pipe[k]  <= '0;
        byp_pipe[k]   <= 1'b0;
        bypd_pipe[k]  <= '0;
      end
    end else begin
      valid_pipe[0] <= rd_acc;
      tag_pipe[0]   <= rd_tag;
      bank_pipe[0]  <= rd_bank;
      byp_pipe[0]   <= bypass;
      bypd_pipe[0]  <= bypass ? wr_data : '0;
      for (int k = 1; k < PL; k++) begin
        valid_pipe[k] <= valid_pipe[k-1];
        tag_pipe[k]   <= tag_pipe[k-1];
        bank_pipe[k]  <= bank_pipe[k-1];
        byp_pipe[k]   <= byp_pipe[k-1];
        bypd_pipe[k]  <= bypd_pipe[k-1];
      end
    end
  end

  // Registered output; data and tag hold between returning reads.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      rd_tag_out <= '0;
    end else begin
      rd_valid <= valid_pipe[PL-1];
      if (valid_pipe[PL-1]) begin
        rd_data    <= byp_pipe[PL-1] ? bypd_pipe[PL-1] : bank_dout[bank_pipe[PL-1]];
        rd_tag_out <= tag_pipe[PL-1];
      end
    end
  end

endmodule

// File: tb/tb_uram_bank_fwd.sv
module tb_uram_bank_fwd;
  localparam int IW = 4;
  localparam int BB = 1;
  localparam int AW = IW + BB;
  localparam int DW = 64;
  localparam int L  = 5;
  localparam int TW = 8;
  localparam int N  = 1 << IW;
  localparam int NA = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [TW-1:0] rd_tag = '0;

  logic          init_done_a, rd_valid_a, init_done_b, rd_valid_b;
  logic [DW-1:0] rd_data_a, rd_data_b;
  logic [TW-1:0] rd_tag_out_a, rd_tag_out_b;

  always #5 clk = ~clk;

  uram_bank_fwd #(.INDEX_WIDTH(IW), .DATA_WIDTH(DW), .BANK_BITS(BB), .READ_LATENCY(L),
                  .TAG_WIDTH(TW), .WRITE_FIRST(1'b1)) dut_wf (
    .clock(clk), .reset(rst), .clear(clear), .init_done(init_done_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_tag(rd_tag),
    .rd_valid(rd_valid_a), .rd_data(rd_data_a), .rd_tag_out(rd_tag_out_a));

  uram_bank_fwd #(.INDEX_WIDTH(IW), .DATA_WIDTH(DW), .BANK_BITS(BB), .READ_LATENCY(L),
                  .TAG_WIDTH(TW), .WRITE_FIRST(1'b0)) dut_rf (
    .clock(clk), .reset(rst), .clear(clear), .init_done(init_done_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_tag(rd_tag),
    .rd_valid(rd_valid_b), .rd_data(rd_data_b), .rd_tag_out(rd_tag_out_b));

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: flat memory plus a queue of promised responses.
  typedef struct {
    longint        due;
    logic [DW-1:0] d_wf;
    logic [DW-1:0] d_rf;
    logic [TW-1:0] tag;
    bit            known;
  } exp_t;

  exp_t          q[$];
  logic [DW-1:0] mem_m [NA];
  int            init_left = N;
  longint        ecount = 0;
  logic [DW-1:0] last_a = '0, last_b = '0;
  logic [TW-1:0] last_tag = '0;
  bit            unk = 1'b0;

  task automatic model_edge();
    exp_t e;
    ecount++;
    if (rst) begin
      q.delete();
      init_left = N;
      foreach (mem_m[i]) mem_m[i] = '0;
      last_a = '0; last_b = '0; last_tag = '0; unk = 1'b0;
    end else if (init_left == 0) begin
      if (rd_en) begin
        e.due   = ecount + L - 1;
        e.d_rf  = mem_m[rd_addr];
        e.d_wf  = (wr_en && wr_addr == rd_addr) ? wr_data : e.d_rf;
        e.tag   = rd_tag;
        e.known = 1'b1;
        q.push_back(e);
      end
      if (wr_en) mem_m[wr_addr] = wr_data;
      if (clear) begin
        foreach (q[i]) q[i].known = 1'b0;
        foreach (mem_m[i]) mem_m[i] = '0;
        init_left = N;
      end
    end else begin
      if (clear) init_left = N;
      else init_left--;
    end
  endtask

  task automatic check_outputs();
    bit exp_v;
    while (q.size() > 0 && q[0].due < ecount) void'(q.pop_front());
    exp_v = (q.size() > 0) && (q[0].due == ecount);
    chk("rd_valid_wf", {63'd0, rd_valid_a}, {63'd0, exp_v});
    chk("rd_valid_rf", {63'd0, rd_valid_b}, {63'd0, exp_v});
    if (exp_v) begin
      if (q[0].known) begin
        last_a = q[0].d_wf; last_b = q[0].d_rf; unk = 1'b0;
      end else begin
        unk = 1'b1;
      end
      last_tag = q[0].tag;
      void'(q.pop_front());
    end
    chk("init_done_wf", {63'd0, init_done_a}, {63'd0, (init_left == 0)});
    chk("init_done_rf", {63'd0, init_done_b}, {63'd0, (init_left == 0)});
    chk("rd_tag_wf", {56'd0, rd_tag_out_a}, {56'd0, last_tag});
    chk("rd_tag_rf", {56'd0, rd_tag_out_b}, {56'd0, last_tag});
    if (!unk) begin
      chk("rd_data_wf", rd_data_a, last_a);
      chk("rd_data_rf", rd_data_b, last_b);
    end
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic read_all(input logic [TW-1:0] tag_base);
    for (int a = 0; a < NA; a++) begin
      rd_en = 1'b1; rd_addr = AW'(a); rd_tag = tag_base + TW'(a);
      cycle();
    end
    rd_en = 1'b0;
    repeat (L + 2) cycle();
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 3 * N && !init_done_a; i++) cycle();
    chk("ready_timeout", {63'd0, init_done_a}, 64'd1);
  endtask

  // lat counts cycles from the read's own cycle to the rd_valid cycle.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!rd_valid_a && lat < 20) begin
      cycle();
      lat++;
    end
  endtask

  typedef struct {
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [AW-1:0] raddr;
    logic [TW-1:0] tag;
    bit            same;
    logic [DW-1:0] exp_wf;
    logic [DW-1:0] exp_rf;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int low, lat, got, first, lastp, vcnt;

    vecs[0] = '{5'd3,  64'hA5A5, 5'd3,  8'h11, 1'b0, 64'hA5A5, 64'hA5A5};
    vecs[1] = '{5'd6,  64'h1,    5'd6,  8'h22, 1'b0, 64'h1,    64'h1};
    vecs[2] = '{5'd6,  64'h2,    5'd6,  8'h33, 1'b1, 64'h2,    64'h1};
    vecs[3] = '{5'd7,  64'hDEAD, 5'd6,  8'h44, 1'b0, 64'h2,    64'h2};
    vecs[4] = '{5'd8,  64'hBEEF, 5'd8,  8'h55, 1'b1, 64'hBEEF, 64'h0};
    vecs[5] = '{5'd9,  64'h1234, 5'd8,  8'h66, 1'b1, 64'hBEEF, 64'hBEEF};
    vecs[6] = '{5'd31, '1,       5'd31, 8'h88, 1'b0, '1,       '1};

    // Reset and initial sweep length.
    repeat (3) cycle();
    rst = 1'b0;
    low = (init_done_a == 1'b0) ? 1 : 0;
    for (int i = 0; i < 40 && !init_done_a; i++) begin
      cycle();
      if (!init_done_a) low++;
    end
    chk("init_low_cycles", 64'(low), 64'(N));
    $display("reset sweep: init_done low for %0d cycles", low);
    read_all(8'h40);

    // Table-driven write/read and collision vectors.
    for (int v = 0; v < 7; v++) begin
      if (!vecs[v].same) begin
        wr_en = 1'b1; wr_addr = vecs[v].waddr; wr_data = vecs[v].wdata;
        cycle();
        wr_en = 1'b0;
      end
      rd_en = 1'b1; rd_addr = vecs[v].raddr; rd_tag = vecs[v].tag;
      if (vecs[v].same) begin
        wr_en = 1'b1; wr_addr = vecs[v].waddr; wr_data = vecs[v].wdata;
      end
      cycle();
      rd_en = 1'b0; wr_en = 1'b0;
      wait_valid(lat);
      chk("vec_latency", 64'(lat), 64'(L));
      chk("vec_data_wf", rd_data_a, vecs[v].exp_wf);
      chk("vec_data_rf", rd_data_b, vecs[v].exp_rf);
      chk("vec_tag_wf", {56'd0, rd_tag_out_a}, {56'd0, vecs[v].tag});
      chk("vec_tag_rf", {56'd0, rd_tag_out_b}, {56'd0, vecs[v].tag});
      $display("vec %0d: w[%0d]=0x%0h r[%0d] tag=0x%0h lat=%0d wf=0x%0h rf=0x%0h",
               v, vecs[v].waddr, vecs[v].wdata, vecs[v].raddr, vecs[v].tag, lat,
               rd_data_a, rd_data_b);
      cycle();
    end

    // Back-to-back reads alternating banks.
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_addr = AW'(i); wr_data = 64'h100 + 64'(i);
      cycle();
    end
    wr_en = 1'b0;
    got = 0; first = -1; lastp = -1;
    for (int c = 0; c < 8 + L + 4; c++) begin
      if (c < 8) begin
        rd_en = 1'b1; rd_addr = AW'(c); rd_tag = TW'(c);
      end else begin
        rd_en = 1'b0;
      end
      cycle();
      if (rd_valid_a) begin
        chk("b2b_data", rd_data_a, 64'h100 + 64'(got));
        chk("b2b_tag", {56'd0, rd_tag_out_a}, 64'(got));
        if (first < 0) first = c;
        lastp = c;
        got++;
      end
    end
    chk("b2b_count", 64'(got), 64'd8);
    chk("b2b_first", 64'(first), 64'(L - 1));
    chk("b2b_span", 64'(lastp - first), 64'd7);
    $display("back-to-back: %0d pulses, first at %0d, last at %0d", got, first, lastp);

    // Clear with three reads in flight; traffic during the sweep is dropped.
    for (int i = 0; i < 3; i++) begin
      rd_en = 1'b1; rd_addr = AW'(i); rd_tag = 8'hC0 + TW'(i);
      cycle();
    end
    rd_en = 1'b0; clear = 1'b1;
    cycle();
    clear = 1'b0;
    vcnt = rd_valid_a ? 1 : 0;
    low = 1;
    for (int i = 0; i < 40; i++) begin
      wr_en = 1'b1; wr_addr = AW'($urandom_range(0, NA - 1)); wr_data = 64'hBAD;
      rd_en = 1'b1; rd_addr = AW'($urandom_range(0, NA - 1)); rd_tag = 8'hEE;
      cycle();
      if (rd_valid_a) vcnt++;
      if (init_done_a) break;
      low++;
    end
    wr_en = 1'b0; rd_en = 1'b0;
    for (int i = 0; i < L + 2; i++) begin
      cycle();
      if (rd_valid_a) vcnt++;
    end
    chk("clear_low_cycles", 64'(low), 64'(N));
    chk("clear_inflight_valids", 64'(vcnt), 64'd3);
    $display("clear: init_done low %0d cycles, %0d in-flight returns", low, vcnt);
    read_all(8'h80);

    // Asynchronous reset with two reads in flight.
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 64'h44;
    cycle();
    wr_en = 1'b0; rd_en = 1'b1; rd_addr = 5'd4; rd_tag = 8'h99;
    cycle();
    rd_en = 1'b0;
    wait_valid(lat);
    chk("pre_reset_data", rd_data_a, 64'h44);
    cycle();
    for (int i = 0; i < 2; i++) begin
      rd_en = 1'b1; rd_addr = AW'(4 + i); rd_tag = 8'hA0 + TW'(i);
      cycle();
    end
    rd_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_valid", {63'd0, rd_valid_a}, 64'd0);
    chk("rst_data", rd_data_a, 64'd0);
    chk("rst_tag", {56'd0, rd_tag_out_a}, 64'd0);
    chk("rst_init_done", {63'd0, init_done_a}, 64'd0);
    $display("reset mid-flight: valid=%0d data=0x%0h tag=0x%0h", rd_valid_a, rd_data_a, rd_tag_out_a);
    cycle();
    cycle();
    rst = 1'b0;
    vcnt = 0;
    for (int i = 0; i < L + 3; i++) begin
      cycle();
      if (rd_valid_a) vcnt++;
    end
    chk("rst_dropped_valids", 64'(vcnt), 64'd0);
    wait_ready();
    read_all(8'h10);

    // Randomised traffic against the model, with occasional clears.
    for (int i = 0; i < 400; i++) begin
      wr_en   = 1'($urandom_range(0, 1));
      wr_addr = AW'($urandom_range(0, NA - 1));
      wr_data = {$urandom, $urandom};
      rd_en   = 1'($urandom_range(0, 1));
      rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, NA - 1));
      rd_tag  = TW'($urandom);
      clear   = ($urandom_range(0, 149) == 0);
      cycle();
    end
    wr_en = 1'b0; rd_en = 1'b0; clear = 1'b0;
    repeat (L + 2) cycle();
    $display("random phase done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
